tick_pair_adder: RTL

- Consumes the square-wave LED output of the divide-by-25M timer stage as its step clock-enable.
- Every toggle of that level (either edge) is one "step". On each step the block reads one operand pair from an internal block RAM, adds the pair and presents the sum plus a one-cycle valid pulse.
- Sum and valid feed the board display/LED stage downstream.
- The operand RAM is written through a simple load port while the block is idle.

---
 rtl/tick_pair_adder_pkg.sv | 19 +
 rtl/tick_pair_adder_bram.sv | 31 +++
 rtl/tick_pair_adder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tick_pair_adder_pkg.sv
// Shared types and constants for the tick_pair_adder slice.
//   state_t      : sequencer states (IDLE, RD_A, RD_B, ADD), 2-bit encoding
//   DEF_DATA_W   : default operand width
//   DEF_DEPTH    : default number of operand pairs
//   STEP_DIVISOR : divide ratio of the upstream timer stage that drives timer_lvl
package tick_pair_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_A,
    RD_B,
    ADD
  } state_t;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_DEPTH    = 16;
  localparam int unsigned STEP_DIVISOR = 25_000_000;

endpackage

// File: rtl/tick_pair_adder_bram.sv
// bram_sp: single-port, write-first, synchronous-read block RAM.
//   clk  : clock
//   we   : write enable
//   addr : word address
//   din  : write data
//   dout : registered read data (1-cycle latency; shows din on a write)
// Contents are not reset.
module bram_sp #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
      dout        <= din;
    end else begin
      dout <= r_mem[addr];
    end
  end

endmodule

// File: rtl/tick_pair_adder.sv
// tick_pair_adder: each toggle of timer_lvl (either edge) is one step; a step
// reads operand pair idx (A at 2*idx, B at 2*idx+1) from the internal RAM,
// adds it and presents the sum with a one-cycle valid pulse.
// Ports:
//   clk, rst_n (async, active-low)
//   timer_lvl            : step level from the timer stage (same clock domain)
//   run_en               : 1 = honour new steps
//   ld_we/ld_addr/ld_data: RAM load port, effective only in IDLE with no pending step
//   sum_o, sum_valid     : last pair sum (DATA_W+1 bits) and its update pulse
//   idx_o                : index of the next pair to process
//   busy, done, overrun  : non-IDLE, last-pair pulse, sticky lost-step flag
//   acc_o                : running pass total, present only when ACCUM_EN is defined
// Build option: `define ACCUM_EN to add acc_o.
module tick_pair_adder
  import tick_pair_adder_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         timer_lvl,
  input  logic                         run_en,
  input  logic                         ld_we,
  input  logic [$clog2(2*DEPTH)-1:0]   ld_addr,
  input  logic [DATA_W-1:0]            ld_data,
  output logic [DATA_W:0]              sum_o,
  output logic                         sum_valid,
  output logic [$clog2(DEPTH)-1:0]     idx_o,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
`ifdef ACCUM_EN
  ,
  output logic [DATA_W+$clog2(DEPTH):0] acc_o
`endif
);

  localparam int unsigned ADDR_W = $clog2(2*DEPTH);
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_lvl_q;
  logic                r_pending;
  logic                w_pending_nxt;
  logic                w_overrun_set;
  logic                r_overrun;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_a_q;
  logic [DATA_W:0]     r_sum;
  logic                r_sum_valid;
  logic                r_done;
  logic                w_step;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_dout;
  logic [DATA_W:0]     w_sum_new;
  logic                w_last;
`ifdef ACCUM_EN
  logic [DATA_W+IDX_W:0] r_acc;
`endif

  bram_sp #(
    .WIDTH  (DATA_W),
    .DEPTH  (2*DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .din  (ld_data),
    .dout (w_ram_dout)
  );

  always_comb begin
    w_step        = (timer_lvl ^ r_lvl_q) & run_en;
    w_ram_we      = ld_we && (r_state == IDLE) && !r_pending;
    // Load owns the port while writing; otherwise the sequencer addresses A in RD_A, B in RD_B.
    w_ram_addr    = w_ram_we ? ld_addr : {r_idx, (r_state == RD_B)};
    w_sum_new     = {1'b0, r_a_q} + {1'b0, w_ram_dout};
    w_last        = (r_idx == IDX_W'(DEPTH - 1));
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_overrun_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ram_we) begin
          // Load wins this cycle; a coincident step is deferred.
          w_pending_nxt = w_step;
        end else if (w_step || r_pending) begin
          w_state_nxt   = RD_A;
          // A fresh step arriving while a deferred one is launched stays queued.
          w_pending_nxt = w_step && r_pending;
        end
      end
      RD_A:    w_state_nxt = RD_B;
      RD_B:    w_state_nxt = ADD;
      ADD:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (r_state != IDLE && w_step) begin
      if (r_pending) w_overrun_set = 1'b1;
      else           w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lvl_q     <= 1'b0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_idx       <= '0;
      r_a_q       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
`ifdef ACCUM_EN
      r_acc       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_lvl_q     <= timer_lvl;
      r_pending   <= w_pending_nxt;
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_overrun_set) r_overrun <= 1'b1;
      if (r_state == RD_B) r_a_q <= w_ram_dout;
      if (r_state == ADD) begin
        r_sum       <= w_sum_new;
        r_sum_valid <= 1'b1;
        r_done      <= w_last;
        r_idx       <= w_last ? '0 : r_idx + IDX_W'(1);
`ifdef ACCUM_EN
        r_acc       <= (r_idx == '0) ? (DATA_W+IDX_W+1)'(w_sum_new)
                                     : r_acc + (DATA_W+IDX_W+1)'(w_sum_new);
`endif
      end
    end
  end

  assign sum_o     = r_sum;
  assign sum_valid = r_sum_valid;
  assign idx_o     = r_idx;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign overrun   = r_overrun;
`ifdef ACCUM_EN
  assign acc_o     = r_acc;
`endif

endmodule
